queue_sensor_encoder: RTL and testbench
=======================================

# queue_sensor_encoder

Front-end that produces the per-direction queue-sensor levels consumed by the intersection controller. For each of the four approaches (north, east, south, west) it synchronizes and debounces two raw loop-detector inputs: an entry loop upstream and a stop-line loop. It turns their rising edges into arrival and departure events and keeps a saturating vehicle count per approach. From that count it drives `sensor_1th` (a vehicle is waiting at position 1) and `sensor_5th` (the queue reaches position 5).

## Interface
- `DEB`, 4: consecutive stable cycles required before a debounced level changes; legal range 1..255.
- `QMAX`, 15: saturation value of each queue counter; must fit in `CNT_W` bits.
- `FAR_POS`, 5: queue length at or above which `sensor_5th` asserts; legal range 1..`QMAX`.
- `CNT_W`, 4: width of each queue counter.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arrive_raw`  in  4  raw entry-loop detectors, bit0 north, bit1 east, bit2 south, bit3 west; asynchronous to `clk`.
- `depart_raw`  in  4  raw stop-line-loop detectors, same bit order; asynchronous.
- `clear_err`  in  1  single-cycle pulse that clears the sticky error flags.
- `sensor_1th`  out  4  per approach: queue count >= 1.
- `sensor_5th`  out  4  per approach: queue count >= `FAR_POS`.
- `queue_len`  out  4*`CNT_W`  packed counts; north at [`CNT_W`-1:0], then east, south, west.
- `overflow`  out  4  sticky flag: arrival seen while the count = `QMAX`.
- `underflow`  out  4  sticky flag: departure seen while the count = 0.

## Operation
- Eight identical input channels (4 arrive, 4 depart). Each channel:
  - two-flop synchronizer, producing `s`;
  - debouncer holding `deb` and a stability counter `dc`:
    - if `s == deb`: `dc <= 0`;
    - else if `dc == DEB-1`: `deb <= s`, `dc <= 0`;
    - else: `dc <= dc + 1`.
  - event pulse = `deb & ~deb_q`, where `deb_q` is `deb` delayed one cycle; exactly one cycle per debounced rising edge.
- Per-approach counter update, evaluated each cycle from arrival pulse A and departure pulse D:
  - A only: increment if count < `QMAX`; if count == `QMAX`, hold the count and set `overflow`.
  - D only: decrement if count > 0; if count == 0, hold at 0 and set `underflow`.
  - A and D together: count unchanged, no flag set.
  - neither: hold.
- `sensor_1th`, `sensor_5th` and `queue_len` are registered from the counter: they reflect the count of the previous cycle.
- `clear_err` clears all `overflow` and `underflow` bits. If a new error is detected in the same cycle, that flag ends set (set wins).
- Approaches are fully independent; no cross-approach interaction.

## Timing
- Reset (`rst_n` low, any time, asynchronous): all synchronizer flops, `deb`, `deb_q`, `dc`, counters and outputs go to 0 immediately. Every output reads 0 while reset is held.
- Reset mid-operation: counts are lost and nothing is restored. A raw input still high after release is debounced from `deb` = 0 and yields one event.
- Latency, raw input steady from edge k: `s` at k+1, `deb` at k+1+`DEB`, counter at k+2+`DEB`, sensor outputs at k+3+`DEB`.
- Glitch rejection: a raw pulse shorter than `DEB` cycles after synchronization produces no event. A low gap shorter than `DEB` cycles does not split one vehicle into two.
- Maximum event rate per channel: one event every 2*`DEB` cycles.
- Counter wrap-around is impossible: the count saturates at `QMAX` and floors at 0.
- `sensor_5th` implies `sensor_1th` in every cycle.

## Test plan
- Reset, then idle: all outputs 0. Assert `rst_n` low mid-queue (north count 7): `queue_len` and both sensors read 0 before the next clock edge.
- North `arrive_raw` high for 10 cycles, `DEB` = 4, raw rising at edge k: north count 1 at edge k+6; `sensor_1th[0]` = 1 at edge k+7; `sensor_5th` stays 0.
- Five clean east arrivals: `sensor_5th[1]` rises after the fifth; one east departure drops it; four more departures clear `sensor_1th[1]`; `underflow` stays 0.
- South arrival and departure debounced pulses land in the same cycle at count 3: count stays 3, no flags set.
- West: 16 arrivals give count 15 and `overflow[3]` = 1. `clear_err` on the same cycle as a 17th arrival leaves `overflow[3]` = 1; a later `clear_err` alone clears it.
- North raw 3-cycle glitch with `DEB` = 4: no count change. Underflow: a departure at count 0 sets `underflow[0]`, and the count stays 0.

Source files
------------

// File: rtl/queue_sensor_encoder.sv
// rtl/queue_sensor_encoder.sv - per-approach loop-detector debounce, event counting and queue sensor levels
module queue_sensor_encoder #(
  parameter int DEB     = 4,
  parameter int QMAX    = 15,
  parameter int FAR_POS = 5,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           arrive_raw,
  input  logic [3:0]           depart_raw,
  input  logic                 clear_err,
  output logic [3:0]           sensor_1th,
  output logic [3:0]           sensor_5th,
  output logic [4*CNT_W-1:0]   queue_len,
  output logic [3:0]           overflow,
  output logic [3:0]           underflow
);

  localparam logic [CNT_W-1:0] QMAX_C = CNT_W'(QMAX);
  localparam logic [CNT_W-1:0] FAR_C  = CNT_W'(FAR_POS);
  localparam logic [7:0]       DEB_LAST = 8'(DEB - 1);

  // Channels 0..3 are arrival loops, 4..7 the matching stop-line loops.
  logic [7:0]       raw, sync1, s, deb, deb_q, ev;
  logic [7:0]       dc [8];
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       sat, empty, arr_only, dep_only, ovf_new, udf_new;

  assign raw = {depart_raw, arrive_raw};
  assign ev  = deb & ~deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 8; i++) dc[i] <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 8; i++) begin
        if (s[i] == deb[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DEB_LAST) begin
          deb[i] <= s[i];
          dc[i]  <= '0;
        end else begin
          dc[i] <= dc[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    sat   = '0;
    empty = '0;
    for (int j = 0; j < 4; j++) begin
      sat[j]   = (cnt[j] == QMAX_C);
      empty[j] = (cnt[j] == '0);
    end
  end

  // Simultaneous arrival and departure cancel and never raise a flag.
  assign arr_only = ev[3:0] & ~ev[7:4];
  assign dep_only = ev[7:4] & ~ev[3:0];
  assign ovf_new  = arr_only & sat;
  assign udf_new  = dep_only & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) cnt[j] <= '0;
      overflow   <= '0;
      underflow  <= '0;
      sensor_1th <= '0;
      sensor_5th <= '0;
      queue_len  <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (arr_only[j] && !sat[j]) begin
          cnt[j] <= cnt[j] + CNT_W'(1);
        end else if (dep_only[j] && !empty[j]) begin
          cnt[j] <= cnt[j] - CNT_W'(1);
        end
        queue_len[j*CNT_W +: CNT_W] <= cnt[j];
        sensor_1th[j] <= !empty[j];
        sensor_5th[j] <= (cnt[j] >= FAR_C);
      end
      // A new error in the clearing cycle survives the clear.
      overflow  <= (clear_err ? 4'b0 : overflow)  | ovf_new;
      underflow <= (clear_err ? 4'b0 : underflow) | udf_new;
    end
  end

endmodule

// File: tb/tb_queue_sensor_encoder.sv
// tb/tb_queue_sensor_encoder.sv - self-checking bench for queue_sensor_encoder
module tb_queue_sensor_encoder;
  localparam int DEB = 4, QMAX = 15, FAR_POS = 5, CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   arrive_raw, depart_raw;
  logic         clear_err;
  logic [3:0]   sensor_1th, sensor_5th, overflow, underflow;
  logic [15:0]  queue_len;

  int errors = 0;
  int checks = 0;

  int         m_cnt [4];
  logic [3:0] m_ovf, m_udf;

  queue_sensor_encoder #(.DEB(DEB), .QMAX(QMAX), .FAR_POS(FAR_POS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .arrive_raw(arrive_raw), .depart_raw(depart_raw),
    .clear_err(clear_err), .sensor_1th(sensor_1th), .sensor_5th(sensor_5th),
    .queue_len(queue_len), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ovf = '0;
    m_udf = '0;
  endtask

  // One counted vehicle on channel ch (0..3 arrival, 4..7 departure).
  task automatic model_event(input int ch);
    int a;
    a = ch % 4;
    if (ch < 4) begin
      if (m_cnt[a] == QMAX) m_ovf[a] = 1'b1;
      else m_cnt[a] = m_cnt[a] + 1;
    end else begin
      if (m_cnt[a] == 0) m_udf[a] = 1'b1;
      else m_cnt[a] = m_cnt[a] - 1;
    end
  endtask

  task automatic set_raw(input int ch, input logic v);
    if (ch < 4) arrive_raw[ch] = v;
    else depart_raw[ch-4] = v;
  endtask

  task automatic vehicle(input int ch, input int width, input int gap);
    set_raw(ch, 1'b1);
    repeat (width) step();
    set_raw(ch, 1'b0);
    repeat (gap) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arrive_raw = '0; depart_raw = '0; clear_err = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (queue_len !== 16'h0) begin errors++; $display("FAIL reset_qlen: got %h expected 0", queue_len); end
    checks++; if ({sensor_1th, sensor_5th} !== 8'h0) begin errors++; $display("FAIL reset_sensors: got %h expected 0", {sensor_1th, sensor_5th}); end
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (queue_len !== 16'h0) begin errors++; $display("FAIL idle_qlen: got %h expected 0", queue_len); end
    checks++; if ({sensor_1th, sensor_5th} !== 8'h0) begin errors++; $display("FAIL idle_sensors: got %h expected 0", {sensor_1th, sensor_5th}); end
    checks++; if ({overflow, underflow} !== 8'h0) begin errors++; $display("FAIL idle_flags: got %h expected 0", {overflow, underflow}); end
  endtask

  task automatic test_latency();
    arrive_raw[0] = 1'b1;
    repeat (7) step();
    checks++; if (sensor_1th[0] !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", sensor_1th[0]); end
    step();
    checks++; if (sensor_1th[0] !== 1'b1) begin errors++; $display("FAIL latency_s1: got %b expected 1", sensor_1th[0]); end
    checks++; if (queue_len[3:0] !== 4'd1) begin errors++; $display("FAIL latency_qlen: got %0d expected 1", queue_len[3:0]); end
    repeat (2) step();
    arrive_raw[0] = 1'b0;
    repeat (12) step();
    model_event(0);
    checks++; if (sensor_5th[0] !== 1'b0) begin errors++; $display("FAIL latency_s5: got %b expected 0", sensor_5th[0]); end
    checks++; if (queue_len[3:0] !== 4'd1) begin errors++; $display("FAIL latency_single: got %0d expected 1", queue_len[3:0]); end
  endtask

  task automatic test_glitch();
    vehicle(0, DEB - 1, 14);
    checks++; if (queue_len[3:0] !== 4'(m_cnt[0])) begin errors++; $display("FAIL glitch: got %0d expected %0d", queue_len[3:0], m_cnt[0]); end
    arrive_raw[0] = 1'b1; repeat (6) step();
    arrive_raw[0] = 1'b0; repeat (DEB - 2) step();
    vehicle(0, 6, 14);
    model_event(0);
    checks++; if (queue_len[3:0] !== 4'(m_cnt[0])) begin errors++; $display("FAIL short_gap: got %0d expected %0d", queue_len[3:0], m_cnt[0]); end
  endtask

  task automatic test_underflow();
    while (m_cnt[0] > 0) begin vehicle(4, 6, 14); model_event(4); end
    checks++; if (underflow[0] !== 1'b0) begin errors++; $display("FAIL udf_before: got %b expected 0", underflow[0]); end
    vehicle(4, 6, 14); model_event(4);
    checks++; if (underflow[0] !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", underflow[0]); end
    checks++; if (queue_len[3:0] !== 4'd0) begin errors++; $display("FAIL udf_floor: got %0d expected 0", queue_len[3:0]); end
  endtask

  task automatic test_east();
    for (int i = 0; i < 5; i++) begin
      vehicle(1, 6, 14); model_event(1);
      checks++; if (sensor_5th[1] !== (m_cnt[1] >= FAR_POS)) begin errors++; $display("FAIL east_s5_up%0d: got %b expected %b", i, sensor_5th[1], m_cnt[1] >= FAR_POS); end
    end
    vehicle(5, 6, 14); model_event(5);
    checks++; if ({sensor_5th[1], sensor_1th[1]} !== 2'b01) begin errors++; $display("FAIL east_s5_down: got %b expected 01", {sensor_5th[1], sensor_1th[1]}); end
    repeat (4) begin vehicle(5, 6, 14); model_event(5); end
    checks++; if (sensor_1th[1] !== 1'b0) begin errors++; $display("FAIL east_s1_clear: got %b expected 0", sensor_1th[1]); end
    checks++; if (underflow[1] !== 1'b0) begin errors++; $display("FAIL east_udf: got %b expected 0", underflow[1]); end
  endtask

  task automatic test_south_simultaneous();
    repeat (3) begin vehicle(2, 6, 14); model_event(2); end
    arrive_raw[2] = 1'b1; depart_raw[2] = 1'b1;
    repeat (6) step();
    arrive_raw[2] = 1'b0; depart_raw[2] = 1'b0;
    repeat (14) step();
    checks++; if (queue_len[11:8] !== 4'd3) begin errors++; $display("FAIL south_count: got %0d expected 3", queue_len[11:8]); end
    checks++; if ({overflow[2], underflow[2]} !== 2'b00) begin errors++; $display("FAIL south_flags: got %b expected 00", {overflow[2], underflow[2]}); end
  endtask

  task automatic test_west_overflow();
    repeat (16) begin vehicle(3, 6, 14); model_event(3); end
    checks++; if (queue_len[15:12] !== 4'd15) begin errors++; $display("FAIL west_sat: got %0d expected 15", queue_len[15:12]); end
    checks++; if (overflow[3] !== 1'b1) begin errors++; $display("FAIL west_ovf: got %b expected 1", overflow[3]); end
    // Arrival pulse reaches the counter on the 7th edge after raw goes high.
    arrive_raw[3] = 1'b1;
    repeat (6) step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    arrive_raw[3] = 1'b0;
    repeat (14) step();
    m_ovf = 4'b1000; m_udf = '0;
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL set_wins: got %b expected %b", overflow, m_ovf); end
    checks++; if (underflow !== m_udf) begin errors++; $display("FAIL clear_udf: got %b expected %b", underflow, m_udf); end
    clear_err = 1'b1; step(); clear_err = 1'b0; step();
    m_ovf = '0;
    checks++; if (overflow !== 4'b0) begin errors++; $display("FAIL clear_ovf: got %b expected 0000", overflow); end
  endtask

  task automatic test_reset_mid();
    repeat (7) begin vehicle(0, 6, 14); model_event(0); end
    checks++; if (queue_len[3:0] !== 4'd7) begin errors++; $display("FAIL mid_pre: got %0d expected 7", queue_len[3:0]); end
    rst_n = 1'b0;
    #2;
    checks++; if (queue_len !== 16'h0) begin errors++; $display("FAIL mid_qlen: got %h expected 0", queue_len); end
    checks++; if ({sensor_1th, sensor_5th} !== 8'h0) begin errors++; $display("FAIL mid_sensors: got %h expected 0", {sensor_1th, sensor_5th}); end
    arrive_raw[0] = 1'b1;
    step(); step();
    rst_n = 1'b1;
    repeat (8) step();
    arrive_raw[0] = 1'b0;
    repeat (14) step();
    model_reset();
    model_event(0);
    checks++; if (queue_len !== 16'h0001) begin errors++; $display("FAIL held_after_reset: got %h expected 0001", queue_len); end
  endtask

  task automatic test_random();
    logic [15:0] exp_q;
    logic [3:0]  exp_1, exp_5;
    int ch;
    for (int n = 0; n < 40; n++) begin
      ch = int'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        vehicle(ch, int'($urandom_range(1, DEB - 1)), 2 * DEB + 6);
      end else begin
        vehicle(ch, int'($urandom_range(DEB, DEB + 4)), 2 * DEB + 6);
        model_event(ch);
      end
      for (int i = 0; i < 4; i++) begin
        exp_q[i*4 +: 4] = 4'(m_cnt[i]);
        exp_1[i] = (m_cnt[i] >= 1);
        exp_5[i] = (m_cnt[i] >= FAR_POS);
      end
      checks++; if (queue_len !== exp_q) begin errors++; $display("FAIL rnd_qlen[%0d]: got %h expected %h", n, queue_len, exp_q); end
      checks++; if ({sensor_1th, sensor_5th} !== {exp_1, exp_5}) begin errors++; $display("FAIL rnd_sensors[%0d]: got %h expected %h", n, {sensor_1th, sensor_5th}, {exp_1, exp_5}); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rnd_flags[%0d]: got %h expected %h", n, {overflow, underflow}, {m_ovf, m_udf}); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_underflow();
    test_east();
    test_south_simultaneous();
    test_west_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
